mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-master, one-slave arbiter that shares the core's single memory port between the instruction fetch unit (IFU, master 0) and the load/store path (LSU, master 1). Masters and slave use a simple valid/ready bus with separate request and response channels. The block sits between the IFU/EXU memory interfaces and the memory model or bus bridge, and serialises their accesses: at most one transaction is outstanding. It adds a response timeout so that a hung slave returns an error instead of stalling the core forever.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask is DATA_W/8 bits
TIMEOUT, 255, maximum cycles in RESP waiting for s_resp_valid before an error response is generated; legal range 1..65535

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ifu_req_valid  in  1  IFU request valid (read only)
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  IFU response valid
ifu_resp_ready  in  1  IFU accepts response
ifu_rdata  out  DATA_W  IFU read data
ifu_resp_err  out  1  IFU response error (timeout)
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte write mask
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU accepts response
lsu_rdata  out  DATA_W  LSU read data
lsu_resp_err  out  1  LSU response error (timeout)
s_req_valid  out  1  slave request valid
s_req_ready  in  1  slave accepts request
s_addr  out  ADDR_W  slave address
s_wen  out  1  slave write enable
s_wdata  out  DATA_W  slave write data
s_wmask  out  DATA_W/8  slave byte mask
s_resp_valid  in  1  slave response valid
s_resp_ready  out  1  arbiter accepts slave response
s_rdata  in  DATA_W  slave read data
busy  out  1  transaction in flight (state != IDLE)
owner_lsu  out  1  current or last owner is LSU

Behaviour:
- States: IDLE, REQ, RESP. Registers: state, owner (0 = IFU, 1 = LSU), timeout counter cnt (16 bits).
- Reset (async, immediate, including mid-transaction): state = IDLE, owner = 0, cnt = 0. All valid and ready outputs are 0 except s_resp_ready = 1. Data outputs are 0, busy = 0, and owner_lsu = 0.
- IDLE:
  - No request is forwarded. All master readies are 0. s_req_valid = 0.
  - s_resp_ready = 1, so any stray slave response is silently dropped.
  - If lsu_req_valid is high, owner <= 1 and go to REQ. Otherwise, if ifu_req_valid is high, owner <= 0 and go to REQ. The LSU has fixed priority.
- REQ:
  - s_req_valid, s_addr, s_wen, s_wdata and s_wmask are combinational from the owner. For IFU: s_wen = 0, s_wdata = 0, s_wmask = 0.
  - The owner's req_ready = s_req_ready. The non-owner's req_ready = 0.
  - On s_req_valid & s_req_ready: cnt <= 0 and go to RESP.
  - If the owner drops valid before the handshake, that is a protocol violation. The arbiter keeps waiting and does not re-arbitrate.
- RESP:
  - The owner's resp_valid = s_resp_valid, rdata = s_rdata and err = 0. s_resp_ready = the owner's resp_ready.
  - The non-owner's resp_valid = 0.
  - On the slave-to-owner handshake, go to IDLE.
  - Otherwise, if s_resp_valid = 0, cnt increments each cycle.
  - When cnt == TIMEOUT and s_resp_valid = 0, the timeout applies:
    - The owner's resp_valid = 1, err = 1, rdata = 0, and s_resp_ready = 0.
    - On the owner's resp_ready, go to IDLE.
    - A later slave response is dropped in IDLE.
  - While in timeout, cnt saturates at TIMEOUT.
- Timing:
  - Minimum transaction is 3 cycles: IDLE grant, REQ handshake, RESP handshake.
  - Back-to-back transactions incur one IDLE cycle. No request/response overlap is allowed.
  - A request arriving while busy waits; its valid must be held until its ready.
- A simultaneous IFU and LSU request in IDLE grants the LSU. The IFU is granted on the next IDLE if it is still requesting.
- A slave response on the same cycle that cnt reaches TIMEOUT wins: it is a normal response with err = 0.
- Non-owner outputs are always 0 (valid, ready, rdata, err).

Test Plan:
- IFU read only: ifu_req_valid=1, ifu_addr=0x80000000; slave has ready=1 and responds 1 cycle later with 0x00100073 -> s_addr=0x80000000 in REQ, ifu_rdata=0x00100073, ifu_resp_err=0, 3 cycles total, lsu_* stay 0.
- Contention: both masters request in the same IDLE cycle (LSU write to 0x80001000, data 0xDEADBEEF, mask 0xF) -> LSU served first with s_wen=1, s_wmask=0xF; the IFU is granted on the following IDLE; owner_lsu goes 1 then 0.
- Backpressure: s_req_ready is held 0 for 4 cycles, then lsu_resp_ready is held 0 for 3 cycles after s_resp_valid -> the arbiter stays in REQ/RESP, the slave sees s_resp_ready=0 until the LSU accepts, and no second request is issued.
- Timeout: TIMEOUT=4 and the slave never responds -> ifu_resp_valid=1 with err=1 and rdata=0 exactly 4 cycles after entering RESP. A subsequent stray s_resp_valid in IDLE is accepted and not forwarded.
- Async reset mid-RESP: assert rst between clock edges -> busy, s_req_valid and the resp_valids go 0 immediately. After release, a new IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction fetch unit (master 0, IFU)
//   and the load/store unit (master 1, LSU). Accesses are serialised, so at
//   most one transaction is outstanding. The LSU has fixed priority when both
//   masters request in the same IDLE cycle. A response timeout turns a hung
//   slave into an error response, so the core never stalls forever.
//
//   State   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no transaction; arbitrate; stray slave responses dropped
//   REQ     | owner's request forwarded to the slave, waiting for s_req_ready
//   RESP    | waiting for the slave response (or timeout) and owner accept
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ifu_req_* / ifu_resp_*   IFU read-only request and response channels
//   lsu_req_* / lsu_resp_*   LSU read/write request and response channels
//   s_req_* / s_resp_*       slave request and response channels
//   busy                     a transaction is in flight (state != IDLE)
//   owner_lsu                the current or most recent owner is the LSU
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic                  ifu_resp_err,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_resp_err,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic [ADDR_W-1:0]     s_addr,
    output logic                  s_wen,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wmask,
    input  logic                  s_resp_valid,
    output logic                  s_resp_ready,
    input  logic [DATA_W-1:0]     s_rdata,
    output logic                  busy,
    output logic                  owner_lsu
);

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_RESP = 2'd2;
    localparam logic [15:0] TO_CNT  = 16'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              own_req_valid;
    logic              own_resp_ready;
    logic              timed_out;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    assign own_req_valid  = owner_q ? lsu_req_valid  : ifu_req_valid;
    assign own_resp_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;

    // A slave response arriving on the cycle the counter hits TIMEOUT wins.
    assign timed_out = (state_q == ST_RESP) && (cnt_q == TO_CNT) && !s_resp_valid;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        s_req_valid  = 1'b0;
        s_addr       = '0;
        s_wen        = 1'b0;
        s_wdata      = '0;
        s_wmask      = '0;
        s_resp_ready = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = '0;

        case (state_q)
            ST_IDLE: begin
                s_resp_ready = 1'b1;
                if (lsu_req_valid) begin
                    owner_d = 1'b1;
                    state_d = ST_REQ;
                end else if (ifu_req_valid) begin
                    owner_d = 1'b0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                s_req_valid = own_req_valid;
                req_ready   = s_req_ready;
                if (owner_q) begin
                    s_addr  = lsu_addr;
                    s_wen   = lsu_wen;
                    s_wdata = lsu_wdata;
                    s_wmask = lsu_wmask;
                end else begin
                    s_addr  = ifu_addr;
                end
                // A dropped owner valid just keeps us waiting here; no re-arbitration.
                if (own_req_valid && s_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                resp_valid   = s_resp_valid | timed_out;
                resp_err     = timed_out;
                resp_rdata   = timed_out ? '0 : s_rdata;
                s_resp_ready = timed_out ? 1'b0 : own_resp_ready;
                if (resp_valid && own_resp_ready) begin
                    state_d = ST_IDLE;
                end else if (!s_resp_valid && (cnt_q != TO_CNT)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Non-owner outputs are forced to zero.
    assign ifu_req_ready  = req_ready  & ~owner_q;
    assign lsu_req_ready  = req_ready  &  owner_q;
    assign ifu_resp_valid = resp_valid & ~owner_q;
    assign lsu_resp_valid = resp_valid &  owner_q;
    assign ifu_resp_err   = resp_err   & ~owner_q;
    assign lsu_resp_err   = resp_err   &  owner_q;
    assign ifu_rdata      = owner_q ? '0 : resp_rdata;
    assign lsu_rdata      = owner_q ? resp_rdata : '0;

    assign busy      = (state_q != ST_IDLE);
    assign owner_lsu = owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays both masters and the slave. A
// transaction driver records what it observes; each test task predicts the
// outcome from the arbitration/timeout rules and compares.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [MW-1:0] s_wmask;
    logic          busy, owner_lsu;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata),
        .busy(busy), .owner_lsu(owner_lsu)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent run_txn call.
    logic          obs_owner;
    logic [AW-1:0] obs_addr;
    logic          obs_wen;
    logic [DW-1:0] obs_wdata;
    logic [MW-1:0] obs_wmask;
    logic [DW-1:0] obs_rdata;
    logic          obs_err;
    logic          obs_sready;
    int            obs_cycles;
    int            obs_bad;
    bit            obs_hung;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction from an IDLE cycle (called at posedge+1).
    // resp_dly: RESP cycle at which the slave raises s_resp_valid (255 = never).
    // acc_dly : cycles the owner holds resp_ready low after seeing resp_valid.
    task automatic run_txn(input bit ireq, input logic [AW-1:0] iaddr,
                           input bit lreq, input logic [AW-1:0] laddr, input bit lwen,
                           input logic [DW-1:0] lwd, input logic [MW-1:0] lwm,
                           input int req_dly, input int resp_dly, input int acc_dly,
                           input logic [DW-1:0] rd);
        bit   hs;
        int   first;
        logic own_v;
        obs_bad = 0; obs_hung = 0; obs_cycles = 0; obs_owner = 1'b0;
        obs_addr = '0; obs_wen = 1'b0; obs_wdata = '0; obs_wmask = '0;
        obs_rdata = '0; obs_err = 1'b0; obs_sready = 1'b0;
        ifu_req_valid = ireq; ifu_addr = iaddr;
        lsu_req_valid = lreq; lsu_addr = laddr; lsu_wen = lwen; lsu_wdata = lwd; lsu_wmask = lwm;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = rd;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || s_req_valid !== 1'b0)
            obs_bad++;
        tick;
        obs_cycles = 1;
        hs = 1'b0;
        for (int c = 0; c < 30 && !hs; c++) begin
            s_req_ready = (c >= req_dly);
            @(negedge clk);
            if (busy !== 1'b1) obs_bad++;
            if (s_req_ready && s_req_valid === 1'b1) begin
                hs = 1'b1;
                if ((ifu_req_ready ^ lsu_req_ready) !== 1'b1) obs_bad++;
                obs_owner = (lsu_req_ready === 1'b1);
                obs_addr = s_addr; obs_wen = s_wen; obs_wdata = s_wdata; obs_wmask = s_wmask;
            end else if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                obs_bad++;
            end
            tick;
            obs_cycles++;
        end
        s_req_ready = 1'b0;
        if (!hs) begin
            obs_hung = 1'b1;
            return;
        end
        if (obs_owner) lsu_req_valid = 1'b0;
        else           ifu_req_valid = 1'b0;
        hs = 1'b0;
        first = -1;
        for (int j = 0; j < 40 && !hs; j++) begin
            s_resp_valid = (j >= resp_dly);
            s_rdata = rd;
            @(negedge clk);
            own_v = obs_owner ? lsu_resp_valid : ifu_resp_valid;
            if (busy !== 1'b1 || s_req_valid !== 1'b0) obs_bad++;
            if (obs_owner) begin
                if (ifu_resp_valid !== 1'b0 || ifu_rdata !== '0 || ifu_resp_err !== 1'b0) obs_bad++;
            end else begin
                if (lsu_resp_valid !== 1'b0 || lsu_rdata !== '0 || lsu_resp_err !== 1'b0) obs_bad++;
            end
            if (own_v === 1'b1 && first < 0) first = j;
            if (first >= 0 && (j - first) >= acc_dly) begin
                ifu_resp_ready = 1'b1;
                lsu_resp_ready = 1'b1;
            end
            #1;
            if (own_v === 1'b1 && ifu_resp_ready) begin
                hs = 1'b1;
                obs_rdata  = obs_owner ? lsu_rdata : ifu_rdata;
                obs_err    = obs_owner ? lsu_resp_err : ifu_resp_err;
                obs_sready = s_resp_ready;
            end else if (s_resp_valid && s_resp_ready !== 1'b0) begin
                obs_bad++;
            end
            tick;
            obs_cycles++;
        end
        if (!hs) obs_hung = 1'b1;
        s_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
        s_req_ready = 0; s_resp_valid = 1'b1; s_rdata = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || owner_lsu !== 1'b0) begin
            errors++; $display("FAIL reset_busy_owner: busy=%b owner_lsu=%b, required 0 0", busy, owner_lsu);
        end
        checks++;
        if ({s_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: got %b, required 00000",
                {s_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
        end
        checks++;
        if (s_resp_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_resp_ready: got %b, required 1", s_resp_ready);
        end
        checks++;
        if (ifu_rdata !== '0 || lsu_rdata !== '0 || s_addr !== '0 || s_wdata !== '0) begin
            errors++; $display("FAIL reset_data: ifu_rdata=%h lsu_rdata=%h s_addr=%h s_wdata=%h, required 0",
                ifu_rdata, lsu_rdata, s_addr, s_wdata);
        end
        s_resp_valid = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_ifu_read;
        run_txn(1, 32'h8000_0000, 0, '0, 0, '0, '0, 0, 0, 0, 32'h0010_0073);
        checks++;
        if (obs_hung || obs_owner !== 1'b0 || obs_addr !== 32'h8000_0000 || obs_wen !== 1'b0) begin
            errors++; $display("FAIL ifu_req: hung=%0d owner=%b addr=%h wen=%b, required owner 0 addr 80000000 wen 0",
                obs_hung, obs_owner, obs_addr, obs_wen);
        end
        checks++;
        if (obs_rdata !== 32'h0010_0073 || obs_err !== 1'b0) begin
            errors++; $display("FAIL ifu_resp: rdata=%h err=%b, required 00100073 0", obs_rdata, obs_err);
        end
        checks++;
        if (obs_cycles !== 3 || obs_bad !== 0) begin
            errors++; $display("FAIL ifu_timing: cycles=%0d bad=%0d, required 3 0", obs_cycles, obs_bad);
        end
    endtask

    task automatic test_contention;
        run_txn(1, 32'h8000_0040, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h1234_5678);
        checks++;
        if (obs_owner !== 1'b1 || owner_lsu !== 1'b1 || obs_addr !== 32'h8000_1000 || obs_wen !== 1'b1 ||
            obs_wdata !== 32'hDEAD_BEEF || obs_wmask !== 4'hF || obs_bad !== 0) begin
            errors++; $display("FAIL contention_lsu: owner=%b owner_lsu=%b addr=%h wen=%b wdata=%h wmask=%h bad=%0d, required 1 1 80001000 1 deadbeef f 0",
                obs_owner, owner_lsu, obs_addr, obs_wen, obs_wdata, obs_wmask, obs_bad);
        end
        run_txn(1, 32'h8000_0040, 0, '0, 0, '0, '0, 0, 1, 0, 32'h0BAD_F00D);
        checks++;
        if (obs_owner !== 1'b0 || owner_lsu !== 1'b0 || obs_addr !== 32'h8000_0040 || obs_wen !== 1'b0 ||
            obs_wmask !== 4'h0 || obs_rdata !== 32'h0BAD_F00D || obs_cycles !== 4 || obs_bad !== 0) begin
            errors++; $display("FAIL contention_ifu: owner=%b owner_lsu=%b addr=%h wen=%b wmask=%h rdata=%h cycles=%0d bad=%0d, required 0 0 80000040 0 0 0badf00d 4 0",
                obs_owner, owner_lsu, obs_addr, obs_wen, obs_wmask, obs_rdata, obs_cycles, obs_bad);
        end
    endtask

    task automatic test_backpressure;
        run_txn(0, '0, 1, 32'h8000_2004, 0, '0, 4'h3, 4, 0, 3, 32'hCAFE_0001);
        checks++;
        if (obs_hung || obs_cycles !== 10 || obs_bad !== 0) begin
            errors++; $display("FAIL backpressure_timing: hung=%0d cycles=%0d bad=%0d, required 0 10 0", obs_hung, obs_cycles, obs_bad);
        end
        checks++;
        if (obs_rdata !== 32'hCAFE_0001 || obs_err !== 1'b0 || obs_sready !== 1'b1) begin
            errors++; $display("FAIL backpressure_resp: rdata=%h err=%b s_resp_ready=%b, required cafe0001 0 1", obs_rdata, obs_err, obs_sready);
        end
    endtask

    task automatic test_timeout;
        run_txn(1, 32'h8000_0100, 0, '0, 0, '0, '0, 0, 255, 0, 32'hFFFF_FFFF);
        checks++;
        if (obs_hung || obs_err !== 1'b1 || obs_rdata !== '0 || obs_sready !== 1'b0) begin
            errors++; $display("FAIL timeout_resp: hung=%0d err=%b rdata=%h s_resp_ready=%b, required 0 1 0 0",
                obs_hung, obs_err, obs_rdata, obs_sready);
        end
        checks++;
        if (obs_cycles !== 2 + TO + 1 || obs_bad !== 0) begin
            errors++; $display("FAIL timeout_latency: cycles=%0d bad=%0d, required %0d 0", obs_cycles, obs_bad, 2 + TO + 1);
        end
        // Stray late slave response in IDLE: accepted and not forwarded.
        s_resp_valid = 1'b1; s_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (s_resp_ready !== 1'b1 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_resp: s_resp_ready=%b ifu_v=%b lsu_v=%b busy=%b, required 1 0 0 0",
                s_resp_ready, ifu_resp_valid, lsu_resp_valid, busy);
        end
        tick;
        s_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL stray_idle: busy=%b, required 0", busy);
        end
        tick;
    endtask

    task automatic test_async_reset;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
        tick;
        s_req_ready = 1'b1;
        tick;
        lsu_req_valid = 1'b0; s_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || owner_lsu !== 1'b1) begin
            errors++; $display("FAIL areset_pre: busy=%b owner_lsu=%b, required 1 1", busy, owner_lsu);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || s_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 ||
            owner_lsu !== 1'b0 || s_resp_ready !== 1'b1) begin
            errors++; $display("FAIL areset_mid: busy=%b s_req_valid=%b ifu_v=%b lsu_v=%b owner_lsu=%b s_resp_ready=%b, required 0 0 0 0 0 1",
                busy, s_req_valid, ifu_resp_valid, lsu_resp_valid, owner_lsu, s_resp_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick;
        run_txn(1, 32'h8000_0200, 0, '0, 0, '0, '0, 1, 2, 1, 32'h7777_0000);
        checks++;
        if (obs_hung || obs_owner !== 1'b0 || obs_rdata !== 32'h7777_0000 || obs_err !== 1'b0 ||
            obs_cycles !== 7 || obs_bad !== 0) begin
            errors++; $display("FAIL areset_after: hung=%0d owner=%b rdata=%h err=%b cycles=%0d bad=%0d, required 0 0 77770000 0 7 0",
                obs_hung, obs_owner, obs_rdata, obs_err, obs_cycles, obs_bad);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int            pat, rq, rs, ac, r, passes;
            logic [AW-1:0] ia, la;
            logic [DW-1:0] wd, rd;
            logic [MW-1:0] wm;
            bit            wen, want_lsu, want_err;
            pat = $urandom_range(1, 3);
            ia = $urandom; la = $urandom; wd = $urandom; wm = MW'($urandom); wen = 1'($urandom);
            passes = (pat == 3) ? 2 : 1;
            for (int p = 0; p < passes; p++) begin
                bit i_on, l_on;
                rq = $urandom_range(0, 3);
                r  = $urandom_range(0, 5);
                rs = (r == 5) ? 255 : r;
                ac = $urandom_range(0, 3);
                rd = $urandom;
                i_on = (pat != 2);
                l_on = (pat != 1) && (p == 0);
                run_txn(i_on, ia, l_on, la, wen, wd, wm, rq, rs, ac, rd);
                want_lsu = l_on;
                want_err = (rs > TO);
                checks++;
                if (obs_hung || obs_owner !== want_lsu || obs_bad !== 0) begin
                    errors++; $display("FAIL rand_owner[%0d.%0d]: hung=%0d owner=%b bad=%0d, required 0 %b 0",
                        n, p, obs_hung, obs_owner, obs_bad, want_lsu);
                end
                checks++;
                if (obs_addr !== (want_lsu ? la : ia) || obs_wen !== (want_lsu & wen) ||
                    obs_wdata !== (want_lsu ? wd : '0) || obs_wmask !== (want_lsu ? wm : '0)) begin
                    errors++; $display("FAIL rand_req[%0d.%0d]: addr=%h wen=%b wdata=%h wmask=%h, required %h %b %h %h",
                        n, p, obs_addr, obs_wen, obs_wdata, obs_wmask, want_lsu ? la : ia, want_lsu & wen,
                        want_lsu ? wd : '0, want_lsu ? wm : '0);
                end
                checks++;
                if (obs_err !== want_err || obs_rdata !== (want_err ? '0 : rd) || obs_sready !== !want_err) begin
                    errors++; $display("FAIL rand_resp[%0d.%0d]: err=%b rdata=%h s_resp_ready=%b, required %b %h %b",
                        n, p, obs_err, obs_rdata, obs_sready, want_err, want_err ? '0 : rd, !want_err);
                end
                checks++;
                if (obs_cycles !== 1 + (rq + 1) + ((want_err ? TO : rs) + ac + 1)) begin
                    errors++; $display("FAIL rand_cycles[%0d.%0d]: cycles=%0d, required %0d",
                        n, p, obs_cycles, 1 + (rq + 1) + ((want_err ? TO : rs) + ac + 1));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_ifu_read;
        test_contention;
        test_backpressure;
        test_timeout;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
